bip_report_tx: RTL
==================

Name: bip_report_tx

Overview:
- Transmit-side companion to the BIP core: once the processor halts, this block snapshots the final program counter, the accumulator and the number of executed cycles.
- It serializes the snapshot into a fixed byte frame and feeds it to the UART transmitter over a valid/ready byte interface.
- Sits between the BIP top level (status outputs) and uart_tx; one report per run.

Parameters:
- NB_BITS, 16, width of accumulator and data path
- NB_PC, 11, width of program counter (INS_MEM_DEPTH 2048)
- NB_CNT, 32, width of cycle counter; must be a multiple of 8
- HEADER, 8'hA5, frame start byte

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  asynchronous reset, active-low (asserted when 0)
- i_halt  input  1  BIP halted (level; held high once HLT executes)
- i_pc  input  NB_PC  BIP program counter
- i_acc  input  NB_BITS  BIP accumulator
- o_tx_data  output  8  byte to uart_tx
- o_tx_valid  output  1  o_tx_data valid
- i_tx_ready  input  1  uart_tx accepts the byte this cycle
- o_done  output  1  frame fully transmitted

Behaviour:
- Reset (i_rst=0, async): state=RUN, cycle counter=0, o_tx_valid=0, o_tx_data=0, o_done=0, byte index=0.
- Cycle counter:
  - In RUN, increments by 1 on every clock edge where i_halt=0.
  - Saturates at all-ones and does not wrap.
  - Frozen in SEND and DONE.
- Frame, 10 bytes for the defaults, MSB first within each field:
  - HEADER
  - PC zero-extended to 16 bits (2 bytes)
  - ACC (NB_BITS/8 bytes)
  - counter (NB_CNT/8 bytes)
  - checksum = XOR of every byte after HEADER
- FSM states RUN, SEND, DONE:
  - RUN -> SEND on the first edge that samples i_halt=1. That edge captures i_pc, i_acc and the counter into a frame shift register and computes the checksum. The same edge drives o_tx_valid=1 with o_tx_data=HEADER, so the first byte is valid one cycle after halt is sampled.
  - SEND: a byte transfers on any edge with o_tx_valid=1 and i_tx_ready=1. On a transfer, the next byte is presented on the following cycle with no idle gap. While i_tx_ready=0, o_tx_data and o_tx_valid hold stable; valid never drops before the transfer.
  - SEND -> DONE on transfer of the checksum byte: o_tx_valid=0 and o_done=1 from the next cycle.
  - DONE is terminal until reset. i_halt toggling is ignored.
- i_halt is ignored while in SEND. The snapshot is not re-captured.
- i_tx_ready=1 while o_tx_valid=0 has no effect.
- Reset mid-frame: o_tx_valid drops immediately (asynchronously) and the frame is abandoned. After release, the block restarts in RUN with counter 0.
- i_halt already high at reset release: the first edge after release enters SEND with a captured count of 0.

Decomposition:
- Shared package bip_report_pkg holds:
  - state encoding (RUN, SEND, DONE)
  - HEADER constant
  - NB_FRAME_BYTES = 1 + 2 + NB_BITS/8 + NB_CNT/8 + 1
  - byte-index width
- One natural sub-module, frame_shifter: parallel load of the frame, byte shift-out on transfer, running XOR for the checksum.
- The FSM and the cycle counter stay in bip_report_tx.

Test Plan:
- Release reset, i_halt=1 after 7 cycles, pc=11'h005, acc=16'h0012, i_tx_ready=1 -> bytes A5 00 05 00 12 00 00 00 07 10, back-to-back, then o_done=1.
- Same run with i_tx_ready low for 3 cycles on every byte -> each byte held stable for 4 cycles, frame content identical, no duplicated or skipped byte.
- Change pc/acc and toggle i_halt during SEND -> transmitted values are the snapshot taken at halt; no second frame after DONE.
- Assert i_rst=0 while byte 4 is pending -> o_tx_valid=0 immediately. After release with a halt after 3 cycles -> new frame with count 00 00 00 03.
- Force the counter to FFFFFFFE, run 5 more cycles, then halt -> count field FF FF FF FF (saturation).
- i_halt=1 at reset release, pc=0, acc=0 -> frame A5 00 00 00 00 00 00 00 00 00, first byte valid on the cycle after the first edge.

Source files
------------

// File: rtl/bip_report_pkg.sv
// -----------------------------------------------------------------------------
// bip_report_pkg
//   Shared definitions for the BIP end-of-run report transmitter.
//   - state_t         : report FSM states (RUN, SEND, DONE)
//   - HEADER_DEF      : default frame start byte
//   - frame_bytes()   : number of bytes in one report frame
//   - byte_idx_width(): width of a counter able to index every frame byte
//   - NB_FRAME_BYTES / NB_BYTE_IDX : values for the default widths
// -----------------------------------------------------------------------------
package bip_report_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  // Header, PC widened to 16 bits, accumulator, cycle count, checksum.
  function automatic int frame_bytes(input int nb_bits, input int nb_cnt);
    return 1 + 2 + nb_bits / 8 + nb_cnt / 8 + 1;
  endfunction

  function automatic int byte_idx_width(input int n_bytes);
    return (n_bytes <= 2) ? 1 : $clog2(n_bytes);
  endfunction

  localparam int NB_FRAME_BYTES = frame_bytes(16, 32);
  localparam int NB_BYTE_IDX    = byte_idx_width(NB_FRAME_BYTES);

endpackage

// File: rtl/frame_shifter.sv
// -----------------------------------------------------------------------------
// frame_shifter
//   Holds one report frame and presents it a byte at a time, MSB field first.
//   On i_load the snapshot is packed as HEADER | PC(16) | ACC | CNT | CHECKSUM,
//   where CHECKSUM is the XOR of every byte after the header. Each i_shift
//   moves the next byte into the output position.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous reset, active-low
//   i_load  : capture i_pc / i_acc / i_cnt into the frame
//   i_shift : current byte has been accepted, advance to the next one
//   i_pc    : program counter snapshot
//   i_acc   : accumulator snapshot
//   i_cnt   : executed-cycle count snapshot
//   o_byte  : byte currently presented
//   o_last  : o_byte is the checksum (final byte of the frame)
// -----------------------------------------------------------------------------
module frame_shifter
  import bip_report_pkg::*;
#(
  parameter int         NB_BITS = 16,
  parameter int         NB_PC   = 11,
  parameter int         NB_CNT  = 32,
  parameter logic [7:0] HEADER  = HEADER_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic [NB_BITS-1:0] i_acc,
  input  logic [NB_CNT-1:0]  i_cnt,
  output logic [7:0]         o_byte,
  output logic               o_last
);

  localparam int NB_FRAME = frame_bytes(NB_BITS, NB_CNT);
  localparam int NB_PAY   = NB_FRAME - 2;
  localparam int NB_IDX   = byte_idx_width(NB_FRAME);

  logic [NB_PAY*8-1:0]   w_payload;
  logic [7:0]            w_chk;
  logic [NB_FRAME*8-1:0] r_frame;
  logic [NB_IDX-1:0]     r_idx;

  // The PC field is always two bytes wide regardless of NB_PC.
  assign w_payload = {16'(i_pc), i_acc, i_cnt};

  // Checksum covers the payload only, never the header.
  always_comb begin
    w_chk = 8'h00;
    for (int b = 0; b < NB_PAY; b++) begin
      w_chk = w_chk ^ w_payload[b*8 +: 8];
    end
  end

  // Frame register and byte index. Shifting zeros in means the output reads
  // 0 once the whole frame has gone out, same as after reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_frame <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_frame <= {HEADER, w_payload, w_chk};
      r_idx   <= '0;
    end else if (i_shift) begin
      r_frame <= {r_frame[NB_FRAME*8-9:0], 8'h00};
      r_idx   <= r_idx + NB_IDX'(1);
    end
  end

  assign o_byte = r_frame[NB_FRAME*8-1 -: 8];
  assign o_last = (r_idx == NB_IDX'(NB_FRAME - 1));

endmodule

// File: rtl/bip_report_tx.sv
// -----------------------------------------------------------------------------
// bip_report_tx
//   End-of-run reporter for the BIP core. Counts executed cycles while the
//   processor runs; when halt is first seen it snapshots PC, ACC and the
//   count into a byte frame and streams it to uart_tx over valid/ready.
//   Exactly one frame per reset.
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous reset, active-low
//   i_halt     : BIP halted (level)
//   i_pc       : BIP program counter
//   i_acc      : BIP accumulator
//   o_tx_data  : byte to uart_tx
//   o_tx_valid : o_tx_data is valid
//   i_tx_ready : uart_tx accepts the byte this cycle
//   o_done     : frame fully transmitted
// -----------------------------------------------------------------------------
module bip_report_tx
  import bip_report_pkg::*;
#(
  parameter int         NB_BITS = 16,
  parameter int         NB_PC   = 11,
  parameter int         NB_CNT  = 32,
  parameter logic [7:0] HEADER  = HEADER_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_halt,
  input  logic [NB_PC-1:0]   i_pc,
  input  logic [NB_BITS-1:0] i_acc,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_done
);

  state_t            r_state;
  state_t            w_next;
  logic [NB_CNT-1:0] r_cnt;
  logic              w_load;
  logic              w_shift;
  logic              w_last;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus frame load/shift strobes. Halt only matters in RUN, so
  // the snapshot is taken once; DONE is left only through reset.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_halt) begin
          w_next = ST_SEND;
          w_load = 1'b1;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // Executed-cycle counter: counts running cycles, sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if ((r_state == ST_RUN) && !i_halt && (r_cnt != '1)) begin
      r_cnt <= r_cnt + NB_CNT'(1);
    end
  end

  frame_shifter #(
    .NB_BITS (NB_BITS),
    .NB_PC   (NB_PC),
    .NB_CNT  (NB_CNT),
    .HEADER  (HEADER)
  ) u_frame_shifter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_pc    (i_pc),
    .i_acc   (i_acc),
    .i_cnt   (r_cnt),
    .o_byte  (o_tx_data),
    .o_last  (w_last)
  );

  // Valid and done come straight from the state register, so an async reset
  // drops valid immediately.
  assign o_tx_valid = (r_state == ST_SEND);
  assign o_done     = (r_state == ST_DONE);

endmodule
